// File: rtl/pio_pkg.sv
// Shared types and constants for the peripheral I/O bus initiator.
package pio_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } pio_state_e;

    // Window base compares against port[15:2]
    localparam int PIO_WIN_W = 14;

    // Read result returned for unmapped or unanswered reads
    localparam logic [7:0] PIO_DFLT_RD = 8'hFF;

    // Each slave owns a strobe pair: write at the even bit, read at the odd bit
    localparam int PIO_RW_WR = 0;
    localparam int PIO_RW_RD = 1;

    function automatic int pio_rw_bit(input int slv, input logic rd);
        return 2 * slv + (rd ? PIO_RW_RD : PIO_RW_WR);
    endfunction

endpackage

// File: rtl/pio_addr_decode.sv
// Port window decoder: compares port[15:2] against each slave base and
// returns a one-hot hit vector. The first entry of the BASE concatenation
// is slave 0, so base k sits at the top of the packed vector minus k.
// On overlapping windows the lowest slave index wins.
module pio_addr_decode
    import pio_pkg::*;
#(
    parameter int                         NSLV = 3,
    parameter logic [NSLV*PIO_WIN_W-1:0]  BASE = '0
) (
    input  logic [PIO_WIN_W-1:0] iWin,
    output logic [NSLV-1:0]      oHit,
    output logic                 oAny
);

    // Priority compare, lowest index first
    always_comb begin
        oHit = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (oHit == '0 && iWin == BASE[(NSLV-1-k)*PIO_WIN_W +: PIO_WIN_W]) begin
                oHit[k] = 1'b1;
            end
        end
    end

    assign oAny = |oHit;

endmodule

// File: rtl/pio_bus_master.sv
// Peripheral I/O bus initiator: takes one byte read/write from the CPU port
// unit, decodes it onto a slave window, issues a single-cycle strobe and
// waits for that slave's ack. Unmapped accesses finish with oErr and 8'hFF.
// Build option PIO_TIMEOUT_EN: when defined, an unanswered access is closed
// after TMO wait cycles with oErr; otherwise WAIT holds until the ack.
module pio_bus_master
    import pio_pkg::*;
#(
    parameter int                         NSLV = 3,
    parameter logic [NSLV*PIO_WIN_W-1:0]  BASE = {14'h0010, 14'h0008, 14'h0018},
    parameter int                         TMO  = 64
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iReq,
    input  logic                   iWr,
    input  logic [15:0]            iPort,
    input  logic [7:0]             iWData,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [7:0]             oRData,
    output logic                   oErr,
    output logic [2*NSLV-1:0]      oRW,
    output logic [1:0]             oAdr,
    output logic [7:0]             oData,
    input  logic [NSLV-1:0]        iAck,
    input  logic [NSLV-1:0][7:0]   iRData
);

    if (TMO < 2 || TMO > 255) begin : g_tmo_range
        $error("pio_bus_master: TMO must be within 2..255");
    end

    pio_state_e       state_q, state_d;
    logic             wr_q, wr_d;
    logic [1:0]       adr_q, adr_d;
    logic [7:0]       data_q, data_d;
    logic [NSLV-1:0]  hit_q, hit_d;
    logic             mapped_q, mapped_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
`ifdef PIO_TIMEOUT_EN
    localparam logic [7:0] TMO_C = 8'(TMO);
    logic [7:0]       cnt_q, cnt_d;
`endif

    logic [NSLV-1:0]  dec_hit;
    logic             dec_any;
    logic [7:0]       sel_rd;
    logic             ack_hit;

    pio_addr_decode #(
        .NSLV (NSLV),
        .BASE (BASE)
    ) u_dec (
        .iWin (iPort[15:2]),
        .oHit (dec_hit),
        .oAny (dec_any)
    );

    // Read data of the selected slave; only acks from that slave count
    always_comb begin
        sel_rd = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (hit_q[k]) sel_rd = sel_rd | iRData[k];
        end
    end

    assign ack_hit = |(iAck & hit_q);

    // Next-state logic: latch request in IDLE, strobe once, wait, complete
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        adr_d    = adr_q;
        data_d   = data_q;
        hit_d    = hit_q;
        mapped_d = mapped_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef PIO_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (iReq) begin
                    wr_d     = iWr;
                    adr_d    = iPort[1:0];
                    data_d   = iWData;
                    hit_d    = dec_hit;
                    mapped_d = dec_any;
                    state_d  = STRB;
                end
            end
            STRB: begin
                // Unmapped accesses pass through here without a strobe
                if (mapped_q) begin
                    state_d = WAIT;
`ifdef PIO_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    err_d   = 1'b1;
                    if (!wr_q) rdata_d = PIO_DFLT_RD;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (ack_hit) begin
                    if (!wr_q) rdata_d = sel_rd;
                    err_d   = 1'b0;
                    state_d = DONE;
`ifdef PIO_TIMEOUT_EN
                end else if (cnt_q == TMO_C) begin
                    err_d   = 1'b1;
                    if (!wr_q) rdata_d = PIO_DFLT_RD;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            adr_q    <= '0;
            data_q   <= '0;
            hit_q    <= '0;
            mapped_q <= 1'b0;
            rdata_q  <= PIO_DFLT_RD;
            err_q    <= 1'b0;
`ifdef PIO_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            hit_q    <= hit_d;
            mapped_q <= mapped_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef PIO_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Strobe is decoded from the STRB state so it can only last one cycle
    always_comb begin
        oRW = '0;
        if (state_q == STRB) begin
            for (int k = 0; k < NSLV; k++) begin
                oRW[pio_rw_bit(k, 1'b1)] = hit_q[k] & ~wr_q;
                oRW[pio_rw_bit(k, 1'b0)] = hit_q[k] &  wr_q;
            end
        end
    end

    assign oBusy  = (state_q != IDLE);
    assign oDone  = (state_q == DONE);
    assign oRData = rdata_q;
    assign oErr   = err_q;
    assign oAdr   = adr_q;
    assign oData  = data_q;

endmodule

// File: doc/pio_bus_master.md
# pio_bus_master

Bus initiator for the on-chip peripheral I/O bus. Accepts single-byte I/O read/write requests from the CPU core's port-I/O unit, decodes the 16-bit port address onto one of NSLV 4-port peripheral windows (PIT, PIC, UART, …), and drives that peripheral's one-cycle RW strobe. It then waits for the peripheral's ack, returns read data and completion to the CPU side, and closes unmapped or unresponsive accesses with a defined result.

## Interface
- NSLV, 3: number of peripheral windows (1..8)
- BASE, {14'h0010, 14'h0008, 14'h0018}: packed NSLV×14-bit window bases (port[15:2]); slave k occupies BASE[k]*4 .. BASE[k]*4+3
- TMO, 64: ack timeout in cycles (2..255)

- iClk  in  1  clock
- iRst  in  1  reset, asynchronous assert, active-low
- iReq  in  1  CPU request, sampled only when oBusy=0
- iWr  in  1  1=write, 0=read (qualifies iReq)
- iPort  in  16  I/O port address
- iWData  in  8  write byte
- oBusy  out  1  transaction in flight
- oDone  out  1  one-cycle completion pulse
- oRData  out  8  read result, valid with oDone, held until next oDone
- oErr  out  1  with oDone: access unmapped or timed out
- oRW  out  2×NSLV  per-slave strobe, bit[2k+1]=read, bit[2k]=write
- oAdr  out  2  register offset iPort[1:0], shared
- oData  out  8  write byte, shared
- iAck  in  NSLV  per-slave ack
- iRData  in  8×NSLV  per-slave read data

## Operation
- Reset values: oBusy=0, oDone=0, oRData=8'hFF, oErr=0, oRW=0, oAdr=0, oData=0; state IDLE, timeout counter 0.
- States: IDLE, STRB, WAIT, DONE.
- IDLE: iReq=1 → latch iWr/iPort/iWData, decode hit vector, oBusy←1, → STRB. iReq while oBusy=1 is ignored (CPU holds off).
- Decode: hit[k] = (iPort[15:2]==BASE[k]). Multiple hits: lowest k wins. No hit → DONE directly with oErr=1, oRData=8'hFF (reads), no strobe.
- STRB: exactly one oRW bit set for one cycle (bit 2k+1 for read, 2k for write); oAdr/oData valid same cycle and held through WAIT; → WAIT, counter←0.
- WAIT: iAck[k]=1 → capture iRData[k] into oRData (reads only; writes leave oRData unchanged), oErr←0, → DONE. Acks from non-selected slaves ignored. Ack in the strobe cycle itself is ignored.
- Timeout: counter increments each WAIT cycle; reaching TMO without ack → DONE, oErr=1, oRData=8'hFF for reads.
- DONE: oDone=1 one cycle, oBusy←0, → IDLE.
- Reset mid-transaction: all outputs to reset values immediately; strobe aborted; no oDone.

## Timing
- Strobe is strictly one cycle, never repeated within a transaction.
- Mapped access, peripheral acking one cycle after strobe: iReq at T → oRW at T+1 → iAck at T+2 → oDone at T+3; new iReq accepted at T+4 (oBusy=0 from T+4).
- Unmapped: iReq at T → oDone at T+2.
- Timeout: oDone at T+2+TMO+1.
- oBusy rises the cycle after iReq acceptance, falls the cycle after oDone.

## Configuration
- PIO_TIMEOUT_EN: defined → timeout counter and timeout path as above. Undefined → counter and TMO check removed; WAIT holds until ack indefinitely; oErr reports unmapped accesses only.

## Structure
- Package pio_pkg: state enum (IDLE/STRB/WAIT/DONE), PIO_WIN_W=14, PIO_DFLT_RD=8'hFF, strobe bit-index helper constants.
- Sub-module pio_addr_decode: combinational iPort[15:2] vs BASE → one-hot hit vector + hit flag, lowest index priority.

## Test plan
- Write 8'h34 to port 0x0043 (slave 0, BASE 0x0010): oRW[0] pulses one cycle at T+1 with oAdr=3, oData=8'h34; ack T+2; oDone T+3, oErr=0.
- Read port 0x0040 with slave 0 returning 8'hA5 on ack: oRW[1] pulses once, oRData=8'hA5 with oDone, oErr=0.
- Read unmapped port 0x0300: no oRW bit ever set; oDone at T+2, oErr=1, oRData=8'hFF.
- PIO_TIMEOUT_EN, TMO=64, slave 1 never acks: oDone at T+67, oErr=1, oRData=8'hFF; slave 2 ack during WAIT of slave 1 ignored.
- iReq held high continuously: requests accepted back-to-back every 4 cycles, second request's iPort sampled only at acceptance.
- iRst low during WAIT: oRW/oBusy/oDone go 0 asynchronously, no oDone after release; next request completes normally.
